// File: rtl/xor_parity_pkg.sv
// Shared mode encoding, stage-1 record type and legal lane counts for xor_parity_acc.
package xor_parity_pkg;

  localparam logic MODE_BEAT = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  localparam int unsigned LANES_2 = 2;
  localparam int unsigned LANES_4 = 4;
  localparam int unsigned LANES_8 = 8;

  localparam int unsigned MaxWidth = 32;
  localparam int unsigned MaxPairs = LANES_8 / 2;

  // Sized for the largest legal configuration; unused pairs/bits are tied to zero.
  typedef struct packed {
    logic                               valid;
    logic                               mode;
    logic                               last;
    logic [MaxPairs-1:0][MaxWidth-1:0]  partials;
  } s1_t;

endpackage

// File: rtl/xor_parity_stage.sv
// One valid/ready register slice: loads whenever empty or when its content is being consumed.
module xor_parity_stage #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o
);

  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 advance;

  always_comb begin
    advance = !valid_q || out_ready_i;
    valid_d = valid_q;
    data_d  = data_q;
    if (advance) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready_o  = rst_ni && advance;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/xor_parity_acc.sv
// Two-stage lane XOR with per-beat and frame-accumulate modes.
// Optional PAR output (XOR-reduce of Z) when XOR_PARITY_ACC_PAR_EN is defined.
module xor_parity_acc
  import xor_parity_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4
) (
  input  logic                   CLK,
  input  logic                   RN,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [LANES*WIDTH-1:0] IN_DATA,
  input  logic                   IN_MODE,
  input  logic                   IN_LAST,
  input  logic                   CLEAR,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [WIDTH-1:0]       Z
`ifdef XOR_PARITY_ACC_PAR_EN
  ,
  output logic                   PAR
`endif
);

  localparam int unsigned Pairs = LANES / 2;
`ifdef XOR_PARITY_ACC_PAR_EN
  localparam int unsigned S2Width = WIDTH + 1;
`else
  localparam int unsigned S2Width = WIDTH;
`endif

  logic [Pairs-1:0][WIDTH-1:0]       pair_x;
  logic [MaxPairs-1:0][MaxWidth-1:0] parts;
  s1_t                               s1_in, s1_out;
  logic                              s1_valid;
  logic [MaxPairs*MaxWidth-1:0]      s1_flat;
  logic [MaxWidth-1:0]               w_full;
  logic [WIDTH-1:0]                  w;
  logic [WIDTH-1:0]                  z_next;
  logic                              s2_in_valid, s2_in_ready;
  logic [S2Width-1:0]                s2_in_data, s2_out_data;
  logic [WIDTH-1:0]                  acc_q, acc_d;

  for (genvar p = 0; p < Pairs; p++) begin : g_pair
    assign pair_x[p] = IN_DATA[2*p*WIDTH +: WIDTH] ^ IN_DATA[(2*p+1)*WIDTH +: WIDTH];
  end

  for (genvar p = 0; p < MaxPairs; p++) begin : g_parts
    if (p < Pairs) begin : g_used
      assign parts[p] = MaxWidth'(pair_x[p]);
    end else begin : g_zero
      assign parts[p] = '0;
    end
  end

  assign s1_in = {IN_VALID, IN_MODE, IN_LAST, parts};

  xor_parity_stage #(
    .DataWidth($bits(s1_t))
  ) u_s1 (
    .clk_i      (CLK),
    .rst_ni     (RN),
    .in_valid_i (IN_VALID),
    .in_ready_o (IN_READY),
    .in_data_i  (s1_in),
    .out_valid_o(s1_valid),
    .out_ready_i(s2_in_ready),
    .out_data_o (s1_out)
  );

  assign s1_flat = s1_out.partials;

  always_comb begin
    w_full = '0;
    for (int unsigned p = 0; p < MaxPairs; p++) begin
      w_full = w_full ^ s1_flat[p*MaxWidth +: MaxWidth];
    end
  end

  assign w = w_full[WIDTH-1:0];

  logic unused_s1;
  assign unused_s1 = ^{s1_out.valid, w_full};

  // Accumulation happens when the S1 beat leaves S1; CLEAR overrides any acc update that cycle.
  always_comb begin
    acc_d       = CLEAR ? '0 : acc_q;
    s2_in_valid = 1'b0;
    z_next      = w;
    if (s1_valid) begin
      if (s1_out.mode == MODE_BEAT) begin
        s2_in_valid = 1'b1;
      end else if (s1_out.last) begin
        s2_in_valid = 1'b1;
        z_next      = CLEAR ? w : (acc_q ^ w);
        if (s2_in_ready) begin
          acc_d = '0;
        end
      end else if (s2_in_ready && !CLEAR) begin
        acc_d = acc_q ^ w;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef XOR_PARITY_ACC_PAR_EN
  assign s2_in_data = {^z_next, z_next};
  assign {PAR, Z}   = s2_out_data;
`else
  assign s2_in_data = z_next;
  assign Z          = s2_out_data;
`endif

  xor_parity_stage #(
    .DataWidth(S2Width)
  ) u_s2 (
    .clk_i      (CLK),
    .rst_ni     (RN),
    .in_valid_i (s2_in_valid),
    .in_ready_o (s2_in_ready),
    .in_data_i  (s2_in_data),
    .out_valid_o(OUT_VALID),
    .out_ready_i(OUT_READY),
    .out_data_o (s2_out_data)
  );

endmodule

// File: doc/xor_parity_acc.md
XOR_PARITY_ACC -- requirements
Module: xor_parity_acc

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each lane word and of Z; legal 1..32.
REQ-002 Parameter LANES, default 4: number of input lane words; legal values 2, 4, 8.
REQ-003 CLK  input  1  single clock, rising-edge.
REQ-004 RN  input  1  reset, synchronous, active-low.
REQ-005 IN_VALID  input  1  input beat valid.
REQ-006 IN_READY  output  1  block accepts the beat this cycle.
REQ-007 IN_DATA  input  LANES*WIDTH  lane words; lane k is bits [k*WIDTH +: WIDTH].
REQ-008 IN_MODE  input  1  0 = per-beat XOR, 1 = frame accumulate; sampled with the beat.
REQ-009 IN_LAST  input  1  final beat of a frame; used only when IN_MODE=1.
REQ-010 CLEAR  input  1  zero the frame accumulator.
REQ-011 OUT_VALID  output  1  result valid.
REQ-012 OUT_READY  input  1  downstream accepts the result.
REQ-013 Z  output  WIDTH  bitwise XOR result.

Function
REQ-014 Per-beat word W SHALL be the bitwise XOR of all LANES lane words.
REQ-015 Datapath SHALL be two register stages: S1 holds LANES/2 pairwise lane XORs plus mode/last; S2 XORs the partials and applies accumulation.
REQ-016 The handshake SHALL transfer on IN_VALID&IN_READY and on OUT_VALID&OUT_READY.
REQ-017 With no stall, a beat accepted at edge t SHALL drive OUT_VALID/Z at edge t+2; sustained throughput is 1 beat/cycle.
REQ-018 Each stage SHALL advance when empty or when its downstream consumes; IN_READY = !S1_valid | S1_advances; there are no bubbles and no data loss under stall.
REQ-019 While OUT_VALID=1 and OUT_READY=0, Z and OUT_VALID SHALL hold stable.
REQ-020 Mode 0 beats SHALL produce one output Z=W each and SHALL leave the accumulator unchanged.
REQ-021 A mode 1 beat with IN_LAST=0 SHALL set acc <= acc^W and SHALL produce no output.
REQ-022 A mode 1 beat with IN_LAST=1 SHALL output Z=acc^W and set acc <= 0.
REQ-023 CLEAR SHALL set acc <= 0 on the next edge and take precedence: a mode 1 non-LAST beat completing S2 in the same cycle is dropped from acc; a LAST beat in the same cycle outputs Z=W.
REQ-024 CLEAR SHALL NOT flush S1/S2 contents or any pending output.
REQ-025 Interleaved mode 0 beats inside a mode 1 frame SHALL NOT disturb acc.

Reset
REQ-026 RN=0 at a rising edge SHALL clear S1/S2 valid, acc, and Z to 0, with OUT_VALID=0.
REQ-027 IN_READY SHALL be 0 while RN=0 and 1 in the first cycle after RN=1.
REQ-028 Reset mid-frame or mid-stall SHALL discard all in-flight beats and the partial accumulation.

Configuration
REQ-029 With macro XOR_PARITY_ACC_PAR_EN defined, an extra output PAR (output, 1 bit) SHALL equal the XOR-reduce of Z, registered alongside Z and held under stall; reset value is 0.
REQ-030 Without XOR_PARITY_ACC_PAR_EN, the PAR port and its logic SHALL be absent.

Structure
REQ-031 Shared package xor_parity_pkg SHALL hold the mode encoding (MODE_BEAT=0, MODE_ACC=1), the S1 stage struct typedef (valid, mode, last, partials) and the legal LANES constants.
REQ-032 Sub-module xor_parity_stage SHALL implement one valid/ready register slice and be instantiated twice.

Verification
REQ-033 WIDTH=8, LANES=4, mode 0, lanes 0x01,0x02,0x04,0x08, OUT_READY=1 -> Z=0x0F exactly 2 cycles after acceptance.
REQ-034 Mode 1 beats with W values 0x11, 0x22, then LAST beat 0x44 -> one output Z=0x77; a following LAST-only beat 0x05 -> Z=0x05.
REQ-035 Stream 6 beats back-to-back with OUT_READY low for 3 cycles mid-stream -> IN_READY drops, Z holds, all 6 results are delivered in order with none lost.
REQ-036 Mode 1 frame with acc=0x3C, CLEAR asserted together with a LAST beat W=0x0A -> Z=0x0A and acc=0 afterwards.
REQ-037 RN low for 1 cycle mid-frame with 2 beats in flight -> OUT_VALID=0, the next frame beginning 0x01 then LAST 0x02 yields Z=0x03.
REQ-038 With XOR_PARITY_ACC_PAR_EN defined, Z=0x0F -> PAR=0; Z=0x07 -> PAR=1.
